// File: rtl/mips_controller_if.sv
// Bus between the multicycle MIPS datapath and its controller.
//   master : datapath side. It drives instr, instr_valid and mem_ready, and it
//            receives the control strobes and selects.
//   slave  : controller side (mips_controller).
interface mips_controller_if;
  logic [31:0] instr;        // fetched instruction word
  logic        instr_valid;  // fetch handshake
  logic        mem_ready;    // data-memory store accepted
  logic        ir_write;     // latch instr into IR
  logic        pc_write;     // update PC
  logic [1:0]  pc_src;       // 00 PC+4, 10 jump target
  logic [3:0]  alu_ctrl;     // 0 addiu, 1 sw, 2 addu, 3 jal
  logic        alu_src_imm;  // ALU arg2 from sign-extended immediate
  logic        reg_write;    // register-file write strobe
  logic        reg_dst_rd;   // destination rd (1) or rt (0)
  logic        link;         // write PC+4 to $31
  logic        mem_write;    // store request, held until mem_ready
  logic        illegal;      // unsupported-instruction flag
  logic [31:0] retired;      // completed-instruction count

  modport master (
    output instr, instr_valid, mem_ready,
    input  ir_write, pc_write, pc_src, alu_ctrl, alu_src_imm, reg_write,
           reg_dst_rd, link, mem_write, illegal, retired
  );

  modport slave (
    input  instr, instr_valid, mem_ready,
    output ir_write, pc_write, pc_src, alu_ctrl, alu_src_imm, reg_write,
           reg_dst_rd, link, mem_write, illegal, retired
  );
endinterface

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM. It supports addiu, addu, sw and jal.
// Ports:
//   clk   : clock. All state changes on the rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : mips_controller_if.slave. It carries the fetch/store handshakes
//           in, and the control strobes, ALU selects and retired count out.
// Build option:
//   MIPS_CTRL_ILLEGAL_TRAP_EN. When defined, an illegal opcode parks the FSM
//   in TRAP with illegal=1 until reset. When undefined, an illegal opcode
//   retires as a NOP.
// Each strobe and select is registered from the state being entered. It is
// therefore high for exactly the cycle(s) the FSM spends in that state.
// ir_write and pc_write pulse in the cycle after the fetch is accepted.
module mips_controller (
  input  logic               clk,
  input  logic               rst_n,
  mips_controller_if.slave   bus
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned RET_W = 32;

  localparam logic [OP_W-1:0]  OP_SPECIAL = 6'b000000;
  localparam logic [OP_W-1:0]  OP_JAL     = 6'b000011;
  localparam logic [OP_W-1:0]  OP_ADDIU   = 6'b001001;
  localparam logic [OP_W-1:0]  OP_SW      = 6'b101011;
  localparam logic [OP_W-1:0]  FN_ADDU    = 6'b100001;

  localparam logic [ALU_W-1:0] ALU_ADDIU  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SW     = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADDU   = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_JAL    = 4'b0011;

  localparam logic [1:0]       PC_SRC_SEQ  = 2'b00;
  localparam logic [1:0]       PC_SRC_JUMP = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM_WRITE,
    S_WRITEBACK,
    S_JUMP
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [OP_W-1:0]    funct_q, funct_d;
  logic [ALU_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               ir_write_q, ir_write_d;
  logic               pc_write_q, pc_write_d;
  logic [1:0]         pc_src_q, pc_src_d;
  logic               alu_src_imm_q, alu_src_imm_d;
  logic               reg_write_q, reg_write_d;
  logic               reg_dst_rd_q, reg_dst_rd_d;
  logic               link_q, link_d;
  logic               mem_write_q, mem_write_d;
  logic               illegal_q, illegal_d;

  // Only the opcode and funct fields steer the controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instr[25:6];

  // Next state, decode latch, and the registered output values for the next state.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    alu_ctrl_d = alu_ctrl_q;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          op_d    = bus.instr[31:26];
          funct_d = bus.instr[5:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OP_ADDIU) begin
          alu_ctrl_d = ALU_ADDIU;
          state_d    = S_EXECUTE;
        end else if (op_q == OP_SW) begin
          alu_ctrl_d = ALU_SW;
          state_d    = S_EXECUTE;
        end else if ((op_q == OP_SPECIAL) && (funct_q == FN_ADDU)) begin
          alu_ctrl_d = ALU_ADDU;
          state_d    = S_EXECUTE;
        end else if (op_q == OP_JAL) begin
          alu_ctrl_d = ALU_JAL;
          state_d    = S_JUMP;
        end else begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          // An unsupported opcode completes as a NOP.
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_EXECUTE: begin
        state_d = (alu_ctrl_q == ALU_SW) ? S_MEM_WRITE : S_WRITEBACK;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase

    retired_d = retired_q + RET_W'(retire);

    // Outputs follow the state being entered, so they line up with that state's cycle.
    ir_write_d    = (state_d == S_DECODE);
    pc_write_d    = (state_d == S_DECODE) || (state_d == S_JUMP);
    pc_src_d      = (state_d == S_JUMP) ? PC_SRC_JUMP : PC_SRC_SEQ;
    alu_src_imm_d = (state_d == S_EXECUTE) && (alu_ctrl_d != ALU_ADDU);
    reg_write_d   = (state_d == S_WRITEBACK) || (state_d == S_JUMP);
    reg_dst_rd_d  = (state_d == S_WRITEBACK) && (alu_ctrl_d == ALU_ADDU);
    link_d        = (state_d == S_JUMP);
    mem_write_d   = (state_d == S_MEM_WRITE);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    illegal_d     = (state_d == S_TRAP);
`else
    illegal_d     = 1'b0;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      op_q          <= '0;
      funct_q       <= '0;
      alu_ctrl_q    <= '0;
      retired_q     <= '0;
      ir_write_q    <= 1'b0;
      pc_write_q    <= 1'b0;
      pc_src_q      <= PC_SRC_SEQ;
      alu_src_imm_q <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_dst_rd_q  <= 1'b0;
      link_q        <= 1'b0;
      mem_write_q   <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      funct_q       <= funct_d;
      alu_ctrl_q    <= alu_ctrl_d;
      retired_q     <= retired_d;
      ir_write_q    <= ir_write_d;
      pc_write_q    <= pc_write_d;
      pc_src_q      <= pc_src_d;
      alu_src_imm_q <= alu_src_imm_d;
      reg_write_q   <= reg_write_d;
      reg_dst_rd_q  <= reg_dst_rd_d;
      link_q        <= link_d;
      mem_write_q   <= mem_write_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.ir_write    = ir_write_q;
  assign bus.pc_write    = pc_write_q;
  assign bus.pc_src      = pc_src_q;
  assign bus.alu_ctrl    = alu_ctrl_q;
  assign bus.alu_src_imm = alu_src_imm_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.reg_dst_rd  = reg_dst_rd_q;
  assign bus.link        = link_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.illegal     = illegal_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller. Stimulus tasks queue the output record
// expected for each active cycle. Active cycles are those where any strobe or
// alu_src_imm is set. A negedge monitor pops and compares those records.
module tb_mips_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_controller_if bus ();

  mips_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm;
    logic        reg_write;
    logic        reg_dst_rd;
    logic        link;
    logic        mem_write;
    logic        illegal;
    logic [31:0] retired;
  } obs_t;

  obs_t        exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_retired = 32'd0;
  logic [3:0]  exp_alu = 4'd0;

  function automatic obs_t sample_bus();
    obs_t o;
    o.ir_write    = bus.ir_write;
    o.pc_write    = bus.pc_write;
    o.pc_src      = bus.pc_src;
    o.alu_ctrl    = bus.alu_ctrl;
    o.alu_src_imm = bus.alu_src_imm;
    o.reg_write   = bus.reg_write;
    o.reg_dst_rd  = bus.reg_dst_rd;
    o.link        = bus.link;
    o.mem_write   = bus.mem_write;
    o.illegal     = bus.illegal;
    o.retired     = bus.retired;
    return o;
  endfunction

  function automatic obs_t mk(input logic ir, input logic pc, input logic [1:0] src,
                              input logic [3:0] alu, input logic imm, input logic rw,
                              input logic rd, input logic lk, input logic mw);
    obs_t o;
    o.ir_write    = ir;
    o.pc_write    = pc;
    o.pc_src      = src;
    o.alu_ctrl    = alu;
    o.alu_src_imm = imm;
    o.reg_write   = rw;
    o.reg_dst_rd  = rd;
    o.link        = lk;
    o.mem_write   = mw;
    o.illegal     = 1'b0;
    o.retired     = exp_retired;
    return o;
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input obs_t o, input string tag);
    exp_q.push_back(o);
    tag_q.push_back(tag);
  endtask

  // Monitor: every active cycle must match the next queued record.
  always @(negedge clk) begin
    obs_t o;
    string t;
    if (rst_n === 1'b1) begin
      o = sample_bus();
      if (o.ir_write | o.pc_write | o.reg_write | o.mem_write | o.link | o.alu_src_imm) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_active_cycle", 64'(o), 64'd0);
        end else begin
          t = tag_q.pop_front();
          check_val(t, 64'(o), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // Fetch handshake. The DECODE cycle shows ir_write and pc_write with pc_src=00.
  task automatic accept(input logic [31:0] w, input string tag);
    push(mk(1'b1, 1'b1, 2'b00, exp_alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), {tag, "_decode"});
    @(negedge clk);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
  endtask

  task automatic do_alu(input logic [31:0] w, input logic is_addu, input string tag);
    accept(w, tag);
    exp_alu = is_addu ? 4'd2 : 4'd0;
    // addu's EXECUTE cycle is silent (alu_src_imm=0, no strobes), so it gets no record.
    if (!is_addu) push(mk(1'b0, 1'b0, 2'b00, exp_alu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), {tag, "_execute"});
    push(mk(1'b0, 1'b0, 2'b00, exp_alu, 1'b0, 1'b1, is_addu, 1'b0, 1'b0), {tag, "_writeback"});
    repeat (3) @(posedge clk);
    exp_retired++;
  endtask

  task automatic do_sw(input logic [31:0] w, input int waits, input logic early_ready, input string tag);
    if (early_ready) bus.mem_ready = 1'b1;
    accept(w, tag);
    exp_alu = 4'd1;
    push(mk(1'b0, 1'b0, 2'b00, exp_alu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), {tag, "_execute"});
    for (int i = 0; i <= waits; i++)
      push(mk(1'b0, 1'b0, 2'b00, exp_alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), {tag, "_memwrite"});
    repeat (2 + waits) @(posedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    exp_retired++;
  endtask

  task automatic do_jal(input logic [31:0] w, input string tag);
    accept(w, tag);
    exp_alu = 4'd3;
    push(mk(1'b0, 1'b1, 2'b10, exp_alu, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), {tag, "_jump"});
    repeat (2) @(posedge clk);
    exp_retired++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outputs", 64'(sample_bus()), 64'd0);
    exp_retired = 32'd0;
    exp_alu     = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.instr       = 32'h0;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    do_reset();

    // Idle FETCH with a junk word present but instr_valid low must stay silent.
    bus.instr = 32'h2408_0005;
    repeat (3) @(posedge clk);
    bus.instr = 32'h0;

    do_alu(32'h2408_0005, 1'b0, "addiu");
    do_alu(32'h0109_5021, 1'b1, "addu");
    do_sw(32'hAD09_0004, 3, 1'b0, "sw_wait3");
    do_jal(32'h0C00_0010, "jal");
    do_alu(32'h2408_0005, 1'b0, "addiu_after_jal");
    @(negedge clk);
    check_val("retired_after_5", 64'(bus.retired), 64'(exp_retired));

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    accept(32'hFC00_0000, "illegal");
    repeat (4) @(posedge clk);
    #1;
    check_val("trap_illegal_flag", 64'(bus.illegal), 64'd1);
    check_val("trap_retired", 64'(bus.retired), 64'(exp_retired));
    repeat (3) @(posedge clk);
    #1;
    check_val("trap_illegal_sticky", 64'(bus.illegal), 64'd1);
    do_reset();
`else
    accept(32'hFC00_0000, "illegal_op");
    @(posedge clk);
    exp_retired++;
    accept(32'h0109_5020, "illegal_funct");
    @(posedge clk);
    exp_retired++;
    @(negedge clk);
    check_val("nop_retired", 64'(bus.retired), 64'(exp_retired));
    check_val("nop_illegal_low", 64'(bus.illegal), 64'd0);
`endif

    // One-cycle store; mem_ready high early must be ignored before MEM_WRITE.
    do_sw(32'hAD09_0004, 0, 1'b1, "sw_fast");

    // Reset pulled in MEM_WRITE, away from any clock edge.
    accept(32'hAD09_0004, "sw_abort");
    exp_alu = 4'd1;
    push(mk(1'b0, 1'b0, 2'b00, exp_alu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "sw_abort_execute");
    push(mk(1'b0, 1'b0, 2'b00, exp_alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "sw_abort_memwrite");
    push(mk(1'b0, 1'b0, 2'b00, exp_alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "sw_abort_memwrite");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check_val("abort_mem_write_before", 64'(bus.mem_write), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_mem_write_drop", 64'(bus.mem_write), 64'd0);
    check_val("abort_retired_zero", 64'(bus.retired), 64'd0);
    check_val("abort_alu_ctrl_zero", 64'(bus.alu_ctrl), 64'd0);
    exp_retired = 32'd0;
    exp_alu     = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // The first rising edge after reset release accepts the fetch.
    do_alu(32'h2408_0005, 1'b0, "addiu_post_reset");
    repeat (2) @(posedge clk);
    #1;
    check_val("final_retired", 64'(bus.retired), 64'd1);
    check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
